regfile_cmd_master: RTL and testbench
=====================================

// Module: regfile_cmd_master
// PURPOSE
//  Initiator-side controller for the 16x16 register file. It accepts one command at a time over a
//  valid/ready channel and drives the register file's readaddr1/readaddr2/writeaddr/writedata/w_en
//  ports. Each command is WRITE, READ, MOVE or ADD. Results return on a valid/ready response channel.
//  It replaces hand-driven w_en: w_en is high for exactly one clk per write command.
// PARAMETERS
//  DATA_W  16  register width
//  ADDR_W  4   register address width (2**ADDR_W registers)
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       asynchronous, active-low reset (0 = reset)
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       controller can accept a command
//  cmd_op        in   2       0=WRITE 1=READ 2=MOVE 3=ADD
//  cmd_rd        in   ADDR_W  destination register
//  cmd_rs1       in   ADDR_W  source 1 (READ/MOVE/ADD)
//  cmd_rs2       in   ADDR_W  source 2 (ADD only)
//  cmd_imm       in   DATA_W  immediate (WRITE only)
//  rsp_valid     out  1       response present
//  rsp_ready     in   1       response consumed
//  rsp_data      out  DATA_W  value written (WRITE/MOVE/ADD) or value read (READ)
//  rf_readaddr1  out  ADDR_W  to register file readaddr1
//  rf_readaddr2  out  ADDR_W  to register file readaddr2
//  rf_readdata1  in   DATA_W  from register file; combinational read
//  rf_readdata2  in   DATA_W  from register file; combinational read
//  rf_writeaddr  out  ADDR_W  to register file writeaddr
//  rf_writedata  out  DATA_W  to register file writedata
//  rf_w_en       out  1       to register file w_en; write commits on clk edge
// BEHAVIOUR
//  - FSM states: IDLE -> EXEC -> (WB, if op != READ) -> RESP -> IDLE.
//  - cmd_ready = (state==IDLE). Accept on clk edge when cmd_valid & cmd_ready.
//    Capture op/rd/rs1/rs2/imm in op_q/rd_q/rs1_q/rs2_q/imm_q.
//  - rf_readaddr1 = rs1_q and rf_readaddr2 = rs2_q at all times.
//  - EXEC (1 cycle): sample rf_readdata1/2. Register res_q:
//    WRITE=imm_q, READ=rd1, MOVE=rd1, ADD=(rd1+rd2) mod 2**DATA_W (carry dropped).
//  - WB (1 cycle): rf_w_en=1, rf_writeaddr=rd_q, rf_writedata=res_q. All three decode from the
//    state/holding regs, so they are glitch-free. rf_w_en=0 in every other state.
//  - RESP: rsp_valid=1, rsp_data=res_q. Both are held stable until rsp_ready is high on a clk edge,
//    then the FSM returns to IDLE.
//  - Latency from accept edge N: READ gives rsp_valid at N+2; others give w_en during N+2 and
//    rsp_valid at N+3.
//  - Throughput: the next accept is one cycle after the response handshake.
//    cmd_valid is ignored outside IDLE.
//  - Hazards:
//    - rd==rs1 / rd==rs2: sources are read in EXEC, before the WB write, so the old value is used.
//    - A command after a write sees the written value, because the write has committed before RESP.
//  - Reset (rst=0, async, any state): state=IDLE; rf_w_en=0; rsp_valid=0; all captured regs and
//    rsp_data=0; rf_* addresses=0.
//    - Reset during WB aborts the write with no partial commit.
//    - cmd_ready=1 while in reset, but no command is captured until rst=1.
// STRUCTURE
//  - Shared package regfile_pkg:
//    - op encodings OP_WRITE/OP_READ/OP_MOVE/OP_ADD
//    - FSM state encoding
//    - DATA_W/ADDR_W defaults
//  - No sub-module. The register file is instantiated beside this block, not inside it.
// TESTING
//  1 Reset 30ns, release; WRITE rd=5 imm=16'hA5A5 -> w_en high exactly 1 cycle, addr 5;
//    rsp_data=A5A5 at N+3.
//  2 After 1: READ rs1=5 -> rsp_data=16'hA5A5 at N+2; w_en stays 0 throughout.
//  3 WRITE r3=16'hFFFF, WRITE r4=16'h0002, ADD rd=3 rs1=3 rs2=4 -> rsp_data=16'h0001 (wrap);
//    READ r3 -> 0001.
//  4 MOVE rd=7 rs1=5 with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable,
//    cmd_ready=0, later cmd ignored.
//  5 Assert rst low mid-WB of WRITE r2=16'h1234 -> w_en drops immediately; after release,
//    READ r2 -> 0000.
//  6 cmd_valid held high with back-to-back READs, rsp_ready=1 -> one accept per 3 cycles,
//    responses in order.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file command master: widths, opcodes, FSM states.
package regfile_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_MOVE  = 2'd2,
      OP_ADD   = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

endpackage

// File: rtl/regfile_cmd_master.sv
// Command-driven initiator for a combinational-read register file: one command in flight,
// write enable pulses for one clock per writing command, result returned over valid/ready.
module regfile_cmd_master
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rf_readaddr1,
   output logic [ADDR_W-1:0] rf_readaddr2,
   input  logic [DATA_W-1:0] rf_readdata1,
   input  logic [DATA_W-1:0] rf_readdata2,
   output logic [ADDR_W-1:0] rf_writeaddr,
   output logic [DATA_W-1:0] rf_writedata,
   output logic              rf_w_en
);

   state_t            state_q;
   state_t            state_d;
   op_t               op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [ADDR_W-1:0] rs1_q;
   logic [ADDR_W-1:0] rs2_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] res_q;
   logic [DATA_W-1:0] result_s;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode; all outputs come straight from the state register.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rf_w_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (op_q == OP_READ) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            rf_w_en = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Result of the captured command; ADD wraps because the sum is truncated to DATA_W.
   always_comb begin
      result_s = imm_q;
      case (op_q)
         OP_WRITE: result_s = imm_q;
         OP_READ:  result_s = rf_readdata1;
         OP_MOVE:  result_s = rf_readdata1;
         OP_ADD:   result_s = DATA_W'(rf_readdata1 + rf_readdata2);
         default:  result_s = imm_q;
      endcase
   end

   // Command capture in IDLE and result capture in EXEC (sources read before any write-back).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q  <= OP_WRITE;
         rd_q  <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         imm_q <= '0;
         res_q <= '0;
      end else begin
         if ((state_q == ST_IDLE) && cmd_valid) begin
            op_q  <= op_t'(cmd_op);
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            imm_q <= cmd_imm;
         end
         if (state_q == ST_EXEC) begin
            res_q <= result_s;
         end
      end
   end

   assign rf_readaddr1 = rs1_q;
   assign rf_readaddr2 = rs2_q;
   assign rf_writeaddr = rd_q;
   assign rf_writedata = res_q;
   assign rsp_data     = res_q;

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Bench for regfile_cmd_master: behavioural register file beside the DUT plus a simple
// array model of the architectural register contents.
module tb_regfile_cmd_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_rd;
   logic [3:0]  cmd_rs1;
   logic [3:0]  cmd_rs2;
   logic [15:0] cmd_imm;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [3:0]  rf_readaddr1;
   logic [3:0]  rf_readaddr2;
   logic [15:0] rf_readdata1;
   logic [15:0] rf_readdata2;
   logic [3:0]  rf_writeaddr;
   logic [15:0] rf_writedata;
   logic        rf_w_en;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] rf_mem [16] = '{default: 16'h0000};
   logic [15:0] model  [16] = '{default: 16'h0000};

   regfile_cmd_master dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_rd       (cmd_rd),
      .cmd_rs1      (cmd_rs1),
      .cmd_rs2      (cmd_rs2),
      .cmd_imm      (cmd_imm),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rf_readaddr1 (rf_readaddr1),
      .rf_readaddr2 (rf_readaddr2),
      .rf_readdata1 (rf_readdata1),
      .rf_readdata2 (rf_readdata2),
      .rf_writeaddr (rf_writeaddr),
      .rf_writedata (rf_writedata),
      .rf_w_en      (rf_w_en)
   );

   always #5 clk = ~clk;

   assign rf_readdata1 = rf_mem[rf_readaddr1];
   assign rf_readdata2 = rf_mem[rf_readaddr2];

   always @(posedge clk) begin
      if (rf_w_en === 1'b1) begin
         rf_mem[rf_writeaddr] <= rf_writedata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one command from IDLE and checks every cycle of it against the model.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                          input logic [3:0] rs2, input logic [15:0] imm, input int hold,
                          input string tag);
      logic [15:0] exp;
      case (op)
         2'd0:    exp = imm;
         2'd3:    exp = 16'(model[rs1] + model[rs2]);
         default: exp = model[rs1];
      endcase
      check({tag, "/idle_ready"}, cmd_ready, 1'b1);
      cmd_op    = op;
      cmd_rd    = rd;
      cmd_rs1   = rs1;
      cmd_rs2   = rs2;
      cmd_imm   = imm;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check({tag, "/exec_ready"}, cmd_ready, 1'b0);
      check({tag, "/exec_wen"}, rf_w_en, 1'b0);
      check({tag, "/exec_valid"}, rsp_valid, 1'b0);
      check({tag, "/raddr1"}, rf_readaddr1, rs1);
      check({tag, "/raddr2"}, rf_readaddr2, rs2);
      @(posedge clk); #1;
      if (op != 2'd1) begin
         check({tag, "/wb_wen"}, rf_w_en, 1'b1);
         check({tag, "/wb_addr"}, rf_writeaddr, rd);
         check({tag, "/wb_data"}, rf_writedata, exp);
         check({tag, "/wb_valid"}, rsp_valid, 1'b0);
         @(posedge clk); #1;
      end
      check({tag, "/resp_wen"}, rf_w_en, 1'b0);
      check({tag, "/resp_valid"}, rsp_valid, 1'b1);
      check({tag, "/resp_data"}, rsp_data, exp);
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_rd    = 4'($urandom_range(0, 15));
         cmd_rs1   = 4'($urandom_range(0, 15));
         cmd_imm   = 16'($urandom);
         @(posedge clk); #1;
         check({tag, "/hold_valid"}, rsp_valid, 1'b1);
         check({tag, "/hold_data"}, rsp_data, exp);
         check({tag, "/hold_ready"}, cmd_ready, 1'b0);
         check({tag, "/hold_wen"}, rf_w_en, 1'b0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, "/done_valid"}, rsp_valid, 1'b0);
      check({tag, "/done_ready"}, cmd_ready, 1'b1);
      if (op != 2'd1) begin
         model[rd] = exp;
      end
   endtask

   initial begin
      logic [15:0] q[$];
      int          accepts;
      int          last;
      bit          took;

      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_rd    = 4'd0;
      cmd_rs1   = 4'd0;
      cmd_rs2   = 4'd0;
      cmd_imm   = 16'h0000;
      rsp_ready = 1'b0;
      #20;
      check("rst/cmd_ready", cmd_ready, 1'b1);
      check("rst/rsp_valid", rsp_valid, 1'b0);
      check("rst/w_en", rf_w_en, 1'b0);
      check("rst/rsp_data", rsp_data, 16'h0000);
      check("rst/raddr1", rf_readaddr1, 4'd0);
      check("rst/waddr", rf_writeaddr, 4'd0);
      #10;
      rst = 1'b1;
      @(posedge clk); #1;

      run_cmd(2'd0, 4'd5, 4'd0, 4'd0, 16'hA5A5, 0, "write_r5");
      run_cmd(2'd1, 4'd0, 4'd5, 4'd0, 16'h0000, 0, "read_r5");
      run_cmd(2'd0, 4'd3, 4'd0, 4'd0, 16'hFFFF, 0, "write_r3");
      run_cmd(2'd0, 4'd4, 4'd0, 4'd0, 16'h0002, 0, "write_r4");
      run_cmd(2'd3, 4'd3, 4'd3, 4'd4, 16'h0000, 0, "add_wrap");
      run_cmd(2'd1, 4'd0, 4'd3, 4'd0, 16'h0000, 0, "read_r3");
      check("r3_after_add", rf_mem[3], 16'h0001);
      run_cmd(2'd2, 4'd7, 4'd5, 4'd0, 16'h0000, 5, "move_stall");

      // Reset lands in the write-back cycle of WRITE r2.
      cmd_op    = 2'd0;
      cmd_rd    = 4'd2;
      cmd_imm   = 16'h1234;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("abort/wb_wen", rf_w_en, 1'b1);
      rst = 1'b0;
      #1;
      check("abort/wen_drop", rf_w_en, 1'b0);
      check("abort/ready", cmd_ready, 1'b1);
      check("abort/waddr", rf_writeaddr, 4'd0);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      check("abort/r2_kept", rf_mem[2], 16'h0000);
      cmd_valid = 1'b0;
      #2;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort/no_capture", cmd_ready, 1'b1);
      run_cmd(2'd1, 4'd0, 4'd2, 4'd0, 16'h0000, 0, "read_r2");

      for (int n = 0; n < 24; n++) begin
         run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 16'($urandom), int'($urandom_range(0, 2)), "rand");
      end

      // Back-to-back READs with cmd_valid and rsp_ready held high.
      accepts   = 0;
      last      = 0;
      took      = 1'b0;
      cmd_op    = 2'd1;
      cmd_rs1   = 4'($urandom_range(0, 15));
      cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && accepts < 6; c++) begin
         if (took) begin
            cmd_rs1 = 4'($urandom_range(0, 15));
         end
         took = 1'b0;
         if (rsp_valid === 1'b1) begin
            check("b2b/rsp_expected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
               check("b2b/data", rsp_data, q.pop_front());
            end
         end
         if (cmd_ready === 1'b1) begin
            if (accepts > 0) begin
               check("b2b/spacing", c - last, 3);
            end
            last = c;
            accepts++;
            q.push_back(model[cmd_rs1]);
            took = 1'b1;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      check("b2b/accepts", accepts, 6);
      for (int i = 0; i < 8 && q.size() > 0; i++) begin
         if (rsp_valid === 1'b1) begin
            check("b2b/drain_data", rsp_data, q.pop_front());
         end
         @(posedge clk); #1;
      end
      check("b2b/all_responses", q.size(), 0);
      rsp_ready = 1'b0;

      for (int r = 0; r < 16; r++) begin
         check("final_regs", rf_mem[r], model[r]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
